prime_bitmap_reader: RTL

//  Consumes the RANGE-bit primality bitmap produced by isPrime (bit i = 1 <=> START+i is prime).

---
 rtl/prime_bitmap_reader_pkg.sv | 22 ++
 rtl/prime_bitmap_reader_lsb_finder.sv | 29 ++
 rtl/prime_bitmap_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/prime_bitmap_reader_pkg.sv
// Shared defaults and FSM encoding for the prime bitmap reader.
// isPrime, this block and the benches all agree on these values.
package prime_bitmap_reader_pkg;

    localparam int DEF_RANGE = 10000;
    localparam int DEF_START = 100;
    localparam int DEF_CHUNK = 32;
    localparam int DEF_NUM_W = 16;
    localparam int DEF_IDX_W = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int pos_w(input int chunk);
        return (chunk > 1) ? $clog2(chunk) : 1;
    endfunction

endpackage

// File: rtl/prime_bitmap_reader_lsb_finder.sv
// Lowest-set-bit encoder over one bitmap window.
// Bits below off_i are ignored.
module prime_bitmap_reader_lsb_finder
    import prime_bitmap_reader_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK,
    parameter int PW    = pos_w(CHUNK)
) (
    input  logic [CHUNK-1:0] win_i,
    input  logic [PW-1:0]    off_i,
    output logic             hit_o,
    output logic [PW-1:0]    pos_o
);

    logic [CHUNK-1:0] masked;

    always_comb begin
        masked = win_i & ({CHUNK{1'b1}} << off_i);
        hit_o  = |masked;
        pos_o  = '0;
        // Walk downward so the lowest set bit wins.
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (masked[i]) begin
                pos_o = PW'(i);
            end
        end
    end

endmodule

// File: rtl/prime_bitmap_reader.sv
// Walks the primality bitmap a chunk per cycle and streams each
// prime ascending on a valid/ready port, counting transfers.
module prime_bitmap_reader
    import prime_bitmap_reader_pkg::*;
#(
    parameter int RANGE = DEF_RANGE,
    parameter int START = DEF_START,
    parameter int CHUNK = DEF_CHUNK,
    parameter int NUM_W = DEF_NUM_W,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RANGE-1:0] bitmap,
    output logic             busy,
    output logic [NUM_W-1:0] prime_data,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic [IDX_W:0]   prime_count,
    output logic             done
);

    localparam int PW = pos_w(CHUNK);
    localparam logic [IDX_W-1:0] ALIGN   = ~IDX_W'(CHUNK - 1);
    localparam logic [IDX_W-1:0] RANGE_I = IDX_W'(RANGE);
    localparam logic [IDX_W-1:0] CHUNK_I = IDX_W'(CHUNK);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic [IDX_W:0]     count_q, count_d;

    logic [RANGE+CHUNK-1:0] pad;
    logic [IDX_W-1:0]       base;
    logic [IDX_W-1:0]       next_base;
    logic [IDX_W-1:0]       hit_idx;
    logic [CHUNK-1:0]       win;
    logic                   hit;
    logic [PW-1:0]          pos;

    // Zero padding makes window bits past the bitmap end read as 0.
    assign pad       = {{CHUNK{1'b0}}, bitmap};
    assign base      = ptr_q & ALIGN;
    assign win       = CHUNK'(pad >> base);
    assign next_base = base + CHUNK_I;
    assign hit_idx   = base + IDX_W'(pos);

    prime_bitmap_reader_lsb_finder #(
        .CHUNK (CHUNK),
        .PW    (PW)
    ) u_find (
        .win_i (win),
        .off_i (ptr_q[PW-1:0]),
        .hit_o (hit),
        .pos_o (pos)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            SCAN: begin
                if (hit) begin
                    data_d  = NUM_W'(START) + NUM_W'(hit_idx);
                    valid_d = 1'b1;
                    ptr_d   = hit_idx + IDX_W'(1);
                    state_d = EMIT;
                end else begin
                    ptr_d = next_base;
                    if (next_base >= RANGE_I) begin
                        state_d = DONE;
                    end
                end
            end
            EMIT: begin
                if (prime_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + (IDX_W + 1)'(1);
                    state_d = (ptr_q >= RANGE_I) ? DONE : SCAN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign busy        = (state_q == SCAN) || (state_q == EMIT);
    assign done        = (state_q == DONE);
    assign prime_data  = data_q;
    assign prime_valid = valid_q;
    assign prime_count = count_q;

endmodule
